// File: rtl/serial_rx_control.sv
// Receive sequencer: start-bit validation, LSB-first data collection, stop-bit check, CPU receive buffer.
// Flags/data update one cycle after the STOP strobe; a full, unread buffer sets overrun and drops the new frame.
module serial_rx_control #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 3
) (
  input  logic                 serial_clock_i,
  input  logic                 serial_reset_i_b,
  input  logic                 serial_rx_enable_i,
  input  logic                 serial_transition_detected_i,
  input  logic                 serial_sample_detected_i,
  input  logic                 serial_shift_i,
  input  logic                 serial_read_i,
  output logic                 serial_clear_count_o,
  output logic [DATA_BITS-1:0] serial_rx_data_o,
  output logic                 serial_rx_full_o,
  output logic                 serial_overrun_o,
  output logic                 serial_framing_error_o,
  output logic                 serial_busy_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_nxt;
  logic [DATA_BITS-1:0] shreg_q, shreg_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic                 clr_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 full_nxt, ovr_nxt, ferr_nxt;

  always_ff @(posedge serial_clock_i) begin
    if (!serial_reset_i_b) begin
      state_q                <= IDLE;
      shreg_q                <= '0;
      cnt_q                  <= '0;
      serial_clear_count_o   <= 1'b0;
      serial_rx_data_o       <= '0;
      serial_rx_full_o       <= 1'b0;
      serial_overrun_o       <= 1'b0;
      serial_framing_error_o <= 1'b0;
    end else begin
      state_q                <= state_nxt;
      shreg_q                <= shreg_nxt;
      cnt_q                  <= cnt_nxt;
      serial_clear_count_o   <= clr_nxt;
      serial_rx_data_o       <= data_nxt;
      serial_rx_full_o       <= full_nxt;
      serial_overrun_o       <= ovr_nxt;
      serial_framing_error_o <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    shreg_nxt = shreg_q;
    cnt_nxt   = cnt_q;
    clr_nxt   = 1'b0;
    data_nxt  = serial_rx_data_o;
    full_nxt  = serial_rx_full_o;
    ovr_nxt   = serial_overrun_o;
    ferr_nxt  = serial_framing_error_o;

    // A read clears the flags; a simultaneous load below overrides this.
    if (serial_read_i) begin
      full_nxt = 1'b0;
      ovr_nxt  = 1'b0;
      ferr_nxt = 1'b0;
    end

    if (!serial_rx_enable_i) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (serial_transition_detected_i) begin
            clr_nxt   = 1'b1;
            state_nxt = START;
          end
        end
        START: begin
          if (serial_shift_i) begin
            if (!serial_sample_detected_i) begin
              state_nxt = DATA;
              cnt_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        DATA: begin
          if (serial_shift_i) begin
            shreg_nxt = {serial_sample_detected_i, shreg_q[DATA_BITS-1:1]};
            cnt_nxt   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_BITS - 1)) state_nxt = STOP;
          end
        end
        STOP: begin
          if (serial_shift_i) begin
            if (!serial_rx_full_o || serial_read_i) begin
              data_nxt = shreg_q;
              full_nxt = 1'b1;
              ferr_nxt = ~serial_sample_detected_i;
            end else begin
              ovr_nxt = 1'b1;
            end
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign serial_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx_control.sv
// Bench for serial_rx_control: directed frame table, hand-written corner sequences, random frames vs. frame-level model.
module tb_serial_rx_control;

  logic       clk = 1'b0;
  logic       rst_b, en, trans, sample, shift, read;
  logic       clr, full, ovr, ferr, busy;
  logic [7:0] rx_data;

  int errors = 0;
  int checks = 0;
  int clr_pulses = 0;
  logic clr_prev = 1'b0;

  // frame-level reference state
  logic [7:0] m_data;
  logic       m_full, m_ovr, m_ferr;

  always #5 clk = ~clk;

  serial_rx_control #(.DATA_BITS(8), .CNT_W(3)) dut (
    .serial_clock_i               (clk),
    .serial_reset_i_b             (rst_b),
    .serial_rx_enable_i           (en),
    .serial_transition_detected_i (trans),
    .serial_sample_detected_i     (sample),
    .serial_shift_i               (shift),
    .serial_read_i                (read),
    .serial_clear_count_o         (clr),
    .serial_rx_data_o             (rx_data),
    .serial_rx_full_o             (full),
    .serial_overrun_o             (ovr),
    .serial_framing_error_o       (ferr),
    .serial_busy_o                (busy)
  );

  always @(negedge clk) begin
    if (clr === 1'b1) begin
      checks++;
      if (clr_prev === 1'b1) begin
        errors++;
        $display("FAIL clear_count_width: high for two consecutive cycles, required single cycle");
      end
      clr_pulses++;
    end
    clr_prev = clr;
  end

  typedef struct {
    logic       rd_before;
    logic [7:0] data;
    logic       stop;
    logic       rd_stop;
    logic [7:0] e_data;
    logic       e_full;
    logic       e_ovr;
    logic       e_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] d, input logic f, input logic o,
                          input logic e, input logic b);
    chk({tag, ".rx_data"}, rx_data, d);
    chk({tag, ".full"}, full, f);
    chk({tag, ".overrun"}, ovr, o);
    chk({tag, ".framing_error"}, ferr, e);
    chk({tag, ".busy"}, busy, b);
  endtask

  task automatic chk_model(input string tag);
    chk_outs(tag, m_data, m_full, m_ovr, m_ferr, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_read();
    m_full = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop, input logic rd);
    if (rd) model_read();
    if (!m_full) begin
      m_data = d;
      m_full = 1'b1;
      m_ferr = ~stop;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_full = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic do_read();
    read = 1'b1;
    tick();
    read = 1'b0;
    model_read();
  endtask

  task automatic shift_bit(input logic s, input logic rd);
    int g;
    g = $urandom_range(1, 3);
    sample = s;
    shift  = 1'b1;
    read   = rd;
    tick();
    shift  = 1'b0;
    read   = 1'b0;
    sample = 1'($urandom);
    repeat (g) tick();
  endtask

  task automatic pulse_start();
    trans = 1'b1;
    tick();
    trans = 1'b0;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd, input logic inject);
    int p0;
    p0 = clr_pulses;
    pulse_start();
    shift_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      // a falling edge mid-frame must not re-sync the sequencer
      if (inject && i == 3) trans = 1'b1;
      shift_bit(d[i], 1'b0);
      trans = 1'b0;
    end
    chk("busy_before_stop", busy, 1'b1);
    shift_bit(stop, rd);
    chk("busy_after_stop", busy, 1'b0);
    chk("clear_count_pulses_per_frame", clr_pulses - p0, 1);
    model_frame(d, stop, rd);
  endtask

  task automatic partial_frame();
    pulse_start();
    shift_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) shift_bit(1'($urandom), 1'b0);
    chk("busy_mid_frame", busy, 1'b1);
  endtask

  initial begin
    int p0;
    int op;

    vecs[0] = '{1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h44, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1};

    rst_b = 1'b0; en = 1'b0; trans = 1'b0; sample = 1'b0; shift = 1'b0; read = 1'b0;
    model_reset();
    repeat (2) tick();
    chk_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.clear_count", clr, 1'b0);
    rst_b = 1'b1;
    en    = 1'b1;
    tick();
    chk_outs("after_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // shift strobes in IDLE do nothing
    shift_bit(1'b0, 1'b0);
    chk_outs("idle_shift", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // false start, then a good frame
    pulse_start();
    chk("false_start.busy_in_start", busy, 1'b1);
    shift_bit(1'b1, 1'b0);
    chk_outs("false_start", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    chk_outs("after_false_start", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read();
    chk_outs("read_clears_full", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].rd_before) do_read();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].rd_stop, 1'(i == 2));
      chk_outs($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_full, vecs[i].e_ovr,
               vecs[i].e_ferr, 1'b0);
    end

    // enable drop mid-frame: immediate IDLE, buffer and flags kept
    partial_frame();
    p0 = clr_pulses;
    en = 1'b0;
    tick();
    chk_outs("enable_drop", 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) shift_bit(1'b1, 1'b0);
    chk_outs("enable_drop_tail_ignored", 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("enable_drop.no_clear_count", clr_pulses - p0, 0);

    // reset mid-frame: everything back to zero
    partial_frame();
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    model_reset();
    chk_outs("reset_mid_frame", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    chk_outs("after_reset_ff", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      if (op < 2) begin
        do_read();
      end else if (op == 2) begin
        pulse_start();
        shift_bit(1'b1, 1'b0);
      end else begin
        send_frame(8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 3) == 0));
      end
      chk_model($sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
